// File: rtl/nios_lcd_ctrl_if.sv
// Avalon-MM slave bus bundle for the character-LCD controller.
interface nios_lcd_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, waitrequest
   );
endinterface

// File: rtl/nios_lcd_ctrl.sv
// HD44780 character-LCD sequencer: CPU bytes queue in a FIFO, an FSM drives RS/E/DB timing.
// Define LCD_WAITREQ_EN to stall writes to a full FIFO instead of dropping them.
module nios_lcd_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int SETUP_CYC  = 2,
   parameter int EN_CYC     = 12,
   parameter int HOLD_CYC   = 2,
   parameter int EXEC_CYC   = 2000,
   parameter int LONG_CYC   = 82000
) (
   input  logic            clk,
   input  logic            reset_n,
   nios_lcd_ctrl_if.slave  bus,
   output logic [7:0]      lcd_data,
   output logic            lcd_rs,
   output logic            lcd_rw,
   output logic            lcd_en,
   output logic            lcd_on,
   output logic            lcd_blon
);
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int MAX_A    = (LONG_CYC > EXEC_CYC) ? LONG_CYC : EXEC_CYC;
   localparam int MAX_B    = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int MAX_C    = (MAX_B > HOLD_CYC) ? MAX_B : HOLD_CYC;
   localparam int MAX_CYC  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int CW       = $clog2(MAX_CYC + 1);
   localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
   localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
   localparam logic [CW-1:0] LD_LONG  = CW'(LONG_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_EXEC  = 3'd4
   } state_t;

   logic [8:0]    mem_r [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic [AW:0]   count_s;
   logic          full_s;
   logic          fifo_wr_s;
   logic          push_s;
   logic          pop_s;
   logic          busy_s;
   logic          ovf_set_s;
   logic          ovf_clr_s;
   logic          ctrl_wr_s;
   logic          is_long_s;
   logic          overflow_r;
   logic [1:0]    ctrl_r;
   state_t        state_r;
   state_t        state_n;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_n;
   logic [7:0]    lcd_data_r;
   logic          lcd_rs_r;
   logic          lcd_en_r;
   logic [31:0]   rdata_s;
   logic          unused_s;

   assign count_s   = wr_ptr_r - rd_ptr_r;
   assign full_s    = (count_s == DEPTH_V);
   assign fifo_wr_s = bus.chipselect & ~bus.write_n & ~bus.address[1];
   assign pop_s     = (state_r == ST_IDLE) & (count_s != '0);
   assign push_s    = fifo_wr_s & (~full_s | pop_s);
   assign busy_s    = (state_r != ST_IDLE) | (count_s != '0);
   assign ovf_clr_s = bus.chipselect & ~bus.write_n & (bus.address == 2'd2) & bus.writedata[1];
   assign ctrl_wr_s = bus.chipselect & ~bus.write_n & (bus.address == 2'd3);
   assign is_long_s = ~lcd_rs_r & ((lcd_data_r == 8'h01) | (lcd_data_r == 8'h02) |
                                   (lcd_data_r == 8'h03));

`ifdef LCD_WAITREQ_EN
   // A full FIFO back-pressures the master, so nothing is ever lost.
   assign bus.waitrequest = fifo_wr_s & full_s & ~pop_s;
   assign ovf_set_s       = 1'b0;
`else
   assign bus.waitrequest = 1'b0;
   assign ovf_set_s       = fifo_wr_s & full_s & ~pop_s;
`endif

   // FIFO storage and wrapping pointers (extra MSB distinguishes full from empty)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= 9'h000;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.address[0], bus.writedata[7:0]};
            wr_ptr_r                <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Sequencer next-state and per-state down-counter reload
   always_comb begin
      state_n = state_r;
      cnt_n   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (pop_s) begin
               state_n = ST_SETUP;
               cnt_n   = LD_SETUP;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == '0) begin
               state_n = ST_PULSE;
               cnt_n   = LD_EN;
            end else begin
               cnt_n = cnt_r - CNT_ONE;
            end
         end
         ST_PULSE: begin
            if (cnt_r == '0) begin
               state_n = ST_HOLD;
               cnt_n   = LD_HOLD;
            end else begin
               cnt_n = cnt_r - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_r == '0) begin
               state_n = ST_EXEC;
               cnt_n   = is_long_s ? LD_LONG : LD_EXEC;
            end else begin
               cnt_n = cnt_r - CNT_ONE;
            end
         end
         ST_EXEC: begin
            if (cnt_r == '0) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Sequencer state and LCD pin registers; E follows the next state so it is glitch-free
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         lcd_data_r <= 8'h00;
         lcd_rs_r   <= 1'b0;
         lcd_en_r   <= 1'b0;
      end else begin
         state_r  <= state_n;
         cnt_r    <= cnt_n;
         lcd_en_r <= (state_n == ST_PULSE);
         if (pop_s) begin
            lcd_rs_r   <= mem_r[rd_ptr_r[AW-1:0]][8];
            lcd_data_r <= mem_r[rd_ptr_r[AW-1:0]][7:0];
         end
      end
   end

   // Sticky overflow flag (a same-cycle set beats a clear) and panel control bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
         ctrl_r     <= 2'b00;
      end else begin
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
         end
         if (ctrl_wr_s) begin
            ctrl_r <= bus.writedata[1:0];
         end
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      rdata_s = 32'h0000_0000;
      case (bus.address)
         2'd2:    rdata_s = {16'h0000, 8'(count_s), 5'b00000, full_s, overflow_r, busy_s};
         2'd3:    rdata_s = {30'h0000_0000, ctrl_r};
         default: rdata_s = 32'h0000_0000;
      endcase
   end

   assign bus.readdata = rdata_s;
   assign lcd_data     = lcd_data_r;
   assign lcd_rs       = lcd_rs_r;
   assign lcd_rw       = 1'b0;
   assign lcd_en       = lcd_en_r;
   assign lcd_on       = ctrl_r[0];
   assign lcd_blon     = ctrl_r[1];
   assign unused_s     = ^bus.writedata[31:8];
endmodule

// File: tb/tb_nios_lcd_ctrl.sv
// Self-checking bench for nios_lcd_ctrl: table vectors, random bursts against a queue model, corner sequences.
module tb_nios_lcd_ctrl;
   localparam int P_DEPTH = 4;
   localparam int P_SETUP = 2;
   localparam int P_EN    = 3;
   localparam int P_HOLD  = 1;
   localparam int P_EXEC  = 5;
   localparam int P_LONG  = 20;
   localparam int PERIOD_BASE = 1 + P_SETUP + P_EN + P_HOLD;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      logic       exp_rs;
      int         exp_post;
   } vec_t;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         t;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   ev_t        mon_q[$];
   int         wid_q[$];
   logic       en_q = 1'b0;
   int         rise_t = 0;

   nios_lcd_ctrl_if bif();

   nios_lcd_ctrl #(
      .FIFO_DEPTH(P_DEPTH), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN),
      .HOLD_CYC(P_HOLD), .EXEC_CYC(P_EXEC), .LONG_CYC(P_LONG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bif),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_en(lcd_en), .lcd_on(lcd_on), .lcd_blon(lcd_blon)
   );

   always #5 clk = ~clk;

   // LCD-side monitor: logs each E pulse (rising-edge cycle and byte) and its width
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (lcd_en && !en_q) begin
         mon_q.push_back('{lcd_rs, lcd_data, cyc});
         rise_t = cyc;
      end
      if (!lcd_en && en_q) wid_q.push_back(cyc - rise_t);
      en_q = lcd_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_wait(input logic rs, input logic [7:0] d);
      return (!rs && d >= 8'h01 && d <= 8'h03) ? P_LONG : P_EXEC;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
      stalls = 0;
      bif.address = a; bif.chipselect = 1'b1; bif.write_n = 1'b0; bif.writedata = d;
      #1;
      while (bif.waitrequest && stalls < 100) begin
         tick();
         stalls++;
      end
      tick();
      bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.address = 2'd0; bif.writedata = 32'h0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      bif.address = a; bif.chipselect = 1'b1; bif.write_n = 1'b1;
      #1;
      d = bif.readdata;
      bif.chipselect = 1'b0; bif.address = 2'd0;
   endtask

   task automatic wait_idle(input int max, output int ok);
      logic [31:0] s;
      ok = 0;
      for (int k = 0; k < max; k++) begin
         read_reg(2'd2, s);
         if (!s[0]) begin ok = 1; break; end
         tick();
      end
   endtask

   task automatic wait_en(input int max, output int ok);
      ok = 0;
      for (int k = 0; k < max; k++) begin
         if (lcd_en) begin ok = 1; break; end
         tick();
      end
   endtask

   task automatic observe(output int pre, output int enw, output int post,
                          output logic rs, output logic [7:0] d, output int ok);
      logic [31:0] s;
      int phase;
      pre = 0; enw = 0; post = 0; rs = 1'b0; d = 8'h00; ok = 0; phase = 0;
      for (int k = 0; k < 200; k++) begin
         read_reg(2'd2, s);
         if (phase == 0) begin
            if (lcd_en) begin phase = 1; enw = 1; rs = lcd_rs; d = lcd_data; end
            else pre++;
         end else if (phase == 1) begin
            if (lcd_en) enw++;
            else phase = 2;
         end
         if (phase == 2) begin
            if (s[0]) post++;
            else begin ok = 1; break; end
         end
         tick();
      end
   endtask

   task automatic clear_mon();
      mon_q.delete();
      wid_q.delete();
   endtask

   initial begin
      vec_t        vecs[8];
      logic [31:0] rd;
      logic [8:0]  exp_q[$];
      logic [1:0]  ra;
      logic [7:0]  rdat, od;
      logic        ors;
      int          st, ok, pre, enw, post, n, n_exp, stall6;

      bif.address = 2'd0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      read_reg(2'd2, rd); check("rst_status", rd, 32'h0);
      read_reg(2'd3, rd); check("rst_ctrl", rd, 32'h0);
      check("rst_pins", {24'h0, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, bif.waitrequest}, 32'h0);

      vecs[0] = '{2'd1, 8'h41, 1'b1, P_HOLD + P_EXEC};
      vecs[1] = '{2'd0, 8'h01, 1'b0, P_HOLD + P_LONG};
      vecs[2] = '{2'd0, 8'h38, 1'b0, P_HOLD + P_EXEC};
      vecs[3] = '{2'd0, 8'h02, 1'b0, P_HOLD + P_LONG};
      vecs[4] = '{2'd0, 8'h03, 1'b0, P_HOLD + P_LONG};
      vecs[5] = '{2'd1, 8'h01, 1'b1, P_HOLD + P_EXEC};
      vecs[6] = '{2'd0, 8'h04, 1'b0, P_HOLD + P_EXEC};
      vecs[7] = '{2'd0, 8'h00, 1'b0, P_HOLD + P_EXEC};
      for (int i = 0; i < 8; i++) begin
         bus_write(vecs[i].addr, {24'hABCDEF, vecs[i].data}, st);
         observe(pre, enw, post, ors, od, ok);
         check("vec_done", ok, 1);
         check("vec_setup", pre, 1 + P_SETUP);
         check("vec_en_width", enw, P_EN);
         check("vec_exec", post, vecs[i].exp_post);
         check("vec_byte", {ors, od}, {vecs[i].exp_rs, vecs[i].data});
      end
      read_reg(2'd1, rd); check("read_addr1_zero", rd, 32'h0);

      clear_mon();
      stall6 = 0;
      for (int i = 0; i < 6; i++) begin
         bus_write(2'd1, {24'h0, 8'h61 + 8'(i)}, st);
         if (i == 5) stall6 = st;
      end
      read_reg(2'd2, rd);
`ifdef LCD_WAITREQ_EN
      check("wr6_stalled", (stall6 > 0 && stall6 < 100) ? 1 : 0, 1);
      check("wr6_status", rd, 32'h0000_0405);
      n_exp = 6;
`else
      check("wr6_no_stall", stall6, 0);
      check("wr6_status", rd, 32'h0000_0407);
      n_exp = 5;
`endif
      wait_idle(400, ok); check("wr6_idle", ok, 1);
      check("wr6_count", mon_q.size(), n_exp);
      for (int i = 0; i < n_exp && i < mon_q.size(); i++)
         check("wr6_byte", {mon_q[i].rs, mon_q[i].data}, {1'b1, 8'h61 + 8'(i)});
      read_reg(2'd2, rd);
`ifdef LCD_WAITREQ_EN
      check("ovf_sticky", rd, 32'h0);
`else
      check("ovf_sticky", rd, 32'h2);
`endif
      bus_write(2'd2, 32'h2, st);
      read_reg(2'd2, rd); check("ovf_clear", rd, 32'h0);

      clear_mon();
      bus_write(2'd1, 32'h55, st);
      wait_en(50, ok); check("ctl_en_seen", ok, 1);
      bus_write(2'd3, 32'hFFFF_FFF3, st);
      check("ctl_pins", {lcd_blon, lcd_on}, 2'b11);
      read_reg(2'd3, rd); check("ctl_readback", rd, 32'h3);
      wait_idle(100, ok); check("ctl_idle", ok, 1);
      check("ctl_pulses", wid_q.size(), 1);
      if (wid_q.size() > 0) check("ctl_width", wid_q[0], P_EN);
      if (mon_q.size() > 0) check("ctl_byte", {mon_q[0].rs, mon_q[0].data}, 9'h155);

      for (int b = 0; b < 8; b++) begin
         clear_mon();
         exp_q.delete();
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            ra = 2'($urandom_range(0, 1));
            rdat = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            bus_write(ra, {24'h0, rdat}, st);
            exp_q.push_back({ra[0], rdat});
         end
         wait_idle(300, ok); check("rnd_idle", ok, 1);
         check("rnd_count", mon_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            check("rnd_byte", {mon_q[i].rs, mon_q[i].data}, exp_q[i]);
            if (i < wid_q.size()) check("rnd_width", wid_q[i], P_EN);
            if (i > 0) check("rnd_spacing", mon_q[i].t - mon_q[i-1].t,
                             PERIOD_BASE + exp_wait(exp_q[i-1][8], exp_q[i-1][7:0]));
         end
      end

      clear_mon();
      bus_write(2'd1, 32'h11, st);
      bus_write(2'd1, 32'h22, st);
      bus_write(2'd1, 32'h33, st);
      wait_en(50, ok); check("rstmid_en_seen", ok, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rstmid_en_low", lcd_en, 1'b0);
      check("rstmid_data", {lcd_data, lcd_rs}, 9'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      read_reg(2'd2, rd); check("rstmid_status", rd, 32'h0);
      read_reg(2'd3, rd); check("rstmid_ctrl", rd, 32'h0);
      check("rstmid_pins", {lcd_on, lcd_blon}, 2'b00);
      tick();
      clear_mon();
      repeat (40) tick();
      check("rstmid_no_resume", mon_q.size(), 0);
      read_reg(2'd2, rd); check("rstmid_fifo_empty", rd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
